div_arbiter: RTL and testbench

- Shares one `divider` instance (unsigned, DATA_WIDTH-bit, stb/ack/err handshake) among NUM_REQ eBPF execution lanes that issue DIV/MOD.
- Round-robin arbitration between lanes; operand preparation for ALU32 vs ALU64.
- eBPF divide-by-zero semantics: DIV → 0, MOD → dividend, with no trap.
- Sits between lane ALU dispatch and the shared divider; one operation in flight.

---
 rtl/ebpf_div_pkg.sv | 12 +
 rtl/divider.sv | 61 ++++++
 rtl/div_arbiter.sv | 102 ++++++++++
 tb/tb_div_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ebpf_div_pkg.sv
// ebpf_div_pkg: shared FSM state, ALU32 operand mask and DIV/MOD op encoding
package ebpf_div_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
    localparam logic [63:0] ALU32_MASK = 64'h0000_0000_FFFF_FFFF;
    localparam logic OP_DIV = 1'b0;
    localparam logic OP_MOD = 1'b1;
endpackage

// File: rtl/divider.sv
// divider: unsigned restoring divider, one quotient bit per cycle, stb/ack/err handshake
module divider #(
    parameter int data_width = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stb,
    input  logic [data_width-1:0] dividend,
    input  logic [data_width-1:0] divisor,
    output logic                  ack,
    output logic                  err,
    output logic [data_width-1:0] quotient,
    output logic [data_width-1:0] remainder
);
    localparam int CW = $clog2(data_width + 1);
    logic                  active;
    logic [CW-1:0]         cnt;
    logic [data_width-1:0] quo, rem, den;
    logic [data_width:0]   r_sh, diff;
    logic                  fits;
    // one restoring step: shift the next dividend bit into the partial remainder
    always_comb begin
        r_sh = {rem, quo[data_width-1]};
        diff = r_sh - {1'b0, den};
        fits = r_sh >= {1'b0, den};
    end
    // load on stb, iterate data_width steps, pulse ack with the final step
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active <= 1'b0;
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            den    <= '0;
            ack    <= 1'b0;
            err    <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (stb) begin
                active <= divisor != '0;
                ack    <= divisor == '0;
                err    <= divisor == '0;
                cnt    <= CW'(data_width);
                quo    <= dividend;
                rem    <= '0;
                den    <= divisor;
            end else if (active) begin
                quo <= {quo[data_width-2:0], fits};
                rem <= fits ? diff[data_width-1:0] : r_sh[data_width-1:0];
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    active <= 1'b0;
                    ack    <= 1'b1;
                end
            end
        end
    end
    assign quotient  = quo;
    assign remainder = rem;
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one divider among eBPF lanes with ALU32 prep and div-by-zero bypass
module div_arbiter
    import ebpf_div_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_op_mod,
    input  logic [NUM_REQ-1:0]            req_alu32,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          busy
);
    localparam logic [DATA_WIDTH-1:0] MASK32 = DATA_WIDTH'(ALU32_MASK);
    localparam logic [NUM_REQ-1:0]    ONE    = NUM_REQ'(1);

    state_t                state;
    logic [IDX_W-1:0]      ptr, lane, g;
    logic                  op_mod, alu32, gnt;
    logic [DATA_WIDTH-1:0] dvd, dvs, result, in_dvd, in_dvs, div_res;
    logic [DATA_WIDTH-1:0] quo, rem;
    logic [IDX_W:0]        pick;
    logic                  div_stb, div_ack, div_err;

    // first valid lane after p (modulo wrap); top bit flags that a lane was found
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [IDX_W-1:0] p);
        int idx;
        rr_pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (v[idx]) rr_pick = {1'b1, IDX_W'(idx)};
        end
    endfunction

    // grant selection, operand masking and result selection
    always_comb begin
        pick    = rr_pick(req_valid, ptr);
        gnt     = pick[IDX_W];
        g       = pick[IDX_W-1:0];
        in_dvd  = req_dividend[g*DATA_WIDTH +: DATA_WIDTH] & (req_alu32[g] ? MASK32 : '1);
        in_dvs  = req_divisor[g*DATA_WIDTH +: DATA_WIDTH] & (req_alu32[g] ? MASK32 : '1);
        div_res = (op_mod == OP_MOD ? rem : quo) & (alu32 ? MASK32 : '1);
    end

    assign req_ready  = (state == IDLE && gnt) ? ONE << g : '0;
    assign resp_valid = (state == RESP) ? ONE << lane : '0;
    assign resp_data  = (state == RESP) ? result : '0;
    assign busy       = state != IDLE;
    assign div_stb    = state == ISSUE;

    // zero divisors resolve in IDLE (DIV -> 0, MOD -> dividend) and skip the divider entirely
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            ptr    <= IDX_W'(NUM_REQ - 1);
            lane   <= '0;
            op_mod <= OP_DIV;
            alu32  <= 1'b0;
            dvd    <= '0;
            dvs    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (gnt) begin
                    lane   <= g;
                    ptr    <= g;
                    op_mod <= req_op_mod[g];
                    alu32  <= req_alu32[g];
                    dvd    <= in_dvd;
                    dvs    <= in_dvs;
                    result <= req_op_mod[g] == OP_MOD ? in_dvd : '0;
                    state  <= in_dvs == '0 ? RESP : ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: if (div_ack | div_err) begin
                    result <= div_res;
                    state  <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    divider #(.data_width(DATA_WIDTH)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .stb       (div_stb),
        .dividend  (dvd),
        .divisor   (dvs),
        .ack       (div_ack),
        .err       (div_err),
        .quotient  (quo),
        .remainder (rem)
    );
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed self-checking bench for div_arbiter
module tb_div_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  v = '0, m = '0, a = '0;
    logic [63:0] dd [4];
    logic [63:0] ds [4];
    logic [3:0]  req_ready, resp_valid;
    logic [63:0] resp_data;
    logic        busy;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (v),
        .req_op_mod   (m),
        .req_alu32    (a),
        .req_dividend ({dd[3], dd[2], dd[1], dd[0]}),
        .req_divisor  ({ds[3], ds[2], ds[1], ds[0]}),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        v = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic send(input int l, input bit mod, input bit a32, input logic [63:0] x,
                        input logic [63:0] y, output int t);
        @(posedge clk); #1;
        m[l] = mod; a[l] = a32; dd[l] = x; ds[l] = y; v[l] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready != 0) break;
        end
        check("accept", {60'd0, req_ready}, 64'd1 << l);
        t = cyc;
        @(posedge clk); #1;
        v[l] = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int l, input logic [63:0] exp, input int lat, input int t);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (resp_valid != 0) break;
        end
        check({tag, "_valid"}, {60'd0, resp_valid}, 64'd1 << l);
        check({tag, "_data"}, resp_data, exp);
        check({tag, "_lat"}, 64'(cyc - t), 64'(lat));
        @(negedge clk);
        check({tag, "_after"}, {59'd0, busy, resp_valid}, 64'd0);
        check({tag, "_data0"}, resp_data, 64'd0);
    endtask

    initial begin
        int t;
        int exp_lane [5] = '{0, 1, 2, 3, 0};
        logic [63:0] exp_res [4] = '{64'd10, 64'd1, 64'd0, 64'd1};
        int exp_lat [4] = '{67, 67, 1, 67};
        int stray;
        for (int i = 0; i < 4; i++) begin dd[i] = '0; ds[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {55'd0, busy, req_ready, resp_valid}, 64'd0);
        check("rst_data", resp_data, 64'd0);
        #1 reset_n = 1'b1;

        send(0, 1'b0, 1'b0, 64'd100, 64'd7, t);
        check("busy_issue", {63'd0, busy}, 64'd1);
        wait_resp("div64", 0, 64'd14, 67, t);

        send(2, 1'b1, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'h1_0000_0007, t);
        wait_resp("mod32", 2, 64'd2, 67, t);

        send(1, 1'b1, 1'b0, 64'h1234, 64'd0, t);
        wait_resp("mod_zero", 1, 64'h1234, 1, t);
        send(1, 1'b0, 1'b0, 64'h1234, 64'd0, t);
        wait_resp("div_zero", 1, 64'd0, 1, t);
        send(3, 1'b0, 1'b1, 64'd55, 64'h1_0000_0000, t);
        wait_resp("div32_zero", 3, 64'd0, 1, t);

        do_reset();
        m = 4'b1010; a = 4'b1000;
        dd[0] = 64'd50; ds[0] = 64'd5;
        dd[1] = 64'd50; ds[1] = 64'd7;
        dd[2] = 64'd99; ds[2] = 64'd0;
        dd[3] = 64'h5_0000_0009; ds[3] = 64'd4;
        @(posedge clk); #1 v = 4'hF;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (req_ready != 0) break;
            end
            check("rr_grant", {60'd0, req_ready}, 64'd1 << exp_lane[k]);
            t = cyc;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (resp_valid != 0) break;
            end
            check("rr_valid", {60'd0, resp_valid}, 64'd1 << exp_lane[k]);
            check("rr_data", resp_data, exp_res[exp_lane[k]]);
            check("rr_lat", 64'(cyc - t), 64'(exp_lat[exp_lane[k]]));
        end
        m = '0; a = '0;

        do_reset();
        send(0, 1'b0, 1'b0, 64'd100, 64'd7, t);
        repeat (10) @(negedge clk);
        check("wait_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_outputs", {55'd0, busy, req_ready, resp_valid}, 64'd0);
        check("midrst_data", resp_data, 64'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        stray = 0;
        repeat (80) begin
            @(negedge clk);
            if (resp_valid != 0 || busy) stray++;
        end
        check("no_stray_resp", 64'(stray), 64'd0);

        send(3, 1'b0, 1'b0, 64'd1000, 64'd10, t);
        wait_resp("lane3", 3, 64'd100, 67, t);

        @(posedge clk); #1;
        m[0] = 1'b1; a[0] = 1'b0; dd[0] = 64'h77; ds[0] = 64'd0;
        m[3] = 1'b0; a[3] = 1'b1; dd[3] = 64'd9; ds[3] = 64'h1_0000_0000;
        v = 4'b1001;
        @(negedge clk);
        check("tie_grant", {60'd0, req_ready}, 64'd1);
        @(posedge clk); #1 v[0] = 1'b0;
        @(negedge clk);
        check("tie_resp0", {60'd0, resp_valid}, 64'd1);
        check("tie_data0", resp_data, 64'h77);
        @(negedge clk);
        check("tie_grant3", {60'd0, req_ready}, 64'd8);
        @(posedge clk); #1 v[3] = 1'b0;
        @(negedge clk);
        check("tie_resp3", {60'd0, resp_valid}, 64'd8);
        check("tie_data3", resp_data, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
